// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and helpers for the pipeline stall/flush sequencer
package pipeline_ctrl_pkg;
   typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} pipe_ctrl_state_t;
   localparam int MC_CNT_W = 7;
   function automatic logic mem_stall_f(input logic ip, input logic ir, input logic dp, input logic dr);
      return (ip & ~ir) | (dp & ~dr);
   endfunction
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard sources in, register load/flush enables out; PIPE_CTRL_PERF_EN adds perf counters
interface pipeline_ctrl_if
`ifdef PIPE_CTRL_PERF_EN
   #(parameter int CNT_W = 32)
`endif
   ;
   logic imem_pending, imem_resp, dmem_pending, dmem_resp;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_uses_rs1, id_uses_rs2, ex_is_load, ex_mispredict, ex_mc_start, ex_mc_done;
   logic load_pc, load_if_id, load_id_exe, load_exe_mem, load_mem_wb;
   logic flush_if_id, flush_id_exe, flush_exe_mem;
   logic mc_timeout;
`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] perf_stall_cycles, perf_flushes, perf_bubbles;
   modport master(
      output imem_pending, imem_resp, dmem_pending, dmem_resp, id_rs1, id_rs2, ex_rd,
             id_uses_rs1, id_uses_rs2, ex_is_load, ex_mispredict, ex_mc_start, ex_mc_done,
      input  load_pc, load_if_id, load_id_exe, load_exe_mem, load_mem_wb,
             flush_if_id, flush_id_exe, flush_exe_mem, mc_timeout,
             perf_stall_cycles, perf_flushes, perf_bubbles
   );
   modport slave(
      input  imem_pending, imem_resp, dmem_pending, dmem_resp, id_rs1, id_rs2, ex_rd,
             id_uses_rs1, id_uses_rs2, ex_is_load, ex_mispredict, ex_mc_start, ex_mc_done,
      output load_pc, load_if_id, load_id_exe, load_exe_mem, load_mem_wb,
             flush_if_id, flush_id_exe, flush_exe_mem, mc_timeout,
             perf_stall_cycles, perf_flushes, perf_bubbles
   );
`else
   modport master(
      output imem_pending, imem_resp, dmem_pending, dmem_resp, id_rs1, id_rs2, ex_rd,
             id_uses_rs1, id_uses_rs2, ex_is_load, ex_mispredict, ex_mc_start, ex_mc_done,
      input  load_pc, load_if_id, load_id_exe, load_exe_mem, load_mem_wb,
             flush_if_id, flush_id_exe, flush_exe_mem, mc_timeout
   );
   modport slave(
      input  imem_pending, imem_resp, dmem_pending, dmem_resp, id_rs1, id_rs2, ex_rd,
             id_uses_rs1, id_uses_rs2, ex_is_load, ex_mispredict, ex_mc_start, ex_mc_done,
      output load_pc, load_if_id, load_id_exe, load_exe_mem, load_mem_wb,
             flush_if_id, flush_id_exe, flush_exe_mem, mc_timeout
   );
`endif
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: flags a load in EX whose destination is read by the instruction in ID
module hazard_detect (
   input  logic       ex_is_load,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   output logic       load_use
);
   // x0 is never a real dependency
   always_comb begin
      load_use = ex_is_load & (ex_rd != 5'd0) &
                 ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
   end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline; PIPE_CTRL_PERF_EN adds saturating perf counters
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int MC_TIMEOUT = 64
`ifdef PIPE_CTRL_PERF_EN
   , parameter int CNT_W = 32
`endif
) (
   input logic           clk,
   input logic           rst,
   pipeline_ctrl_if.slave bus
);
   localparam logic [MC_CNT_W-1:0] MC_LAST = MC_CNT_W'(MC_TIMEOUT - 1);
   pipe_ctrl_state_t state_q, state_d;
   logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
   logic mc_timeout_q, mc_timeout_d;
   logic load_use, mem_stall, in_run, mc_hold, p_flush, p_start, p_bubble, ld_front, ld_mid;
   hazard_detect u_hazard (
      .ex_is_load (bus.ex_is_load),
      .ex_rd      (bus.ex_rd),
      .id_rs1     (bus.id_rs1),
      .id_rs2     (bus.id_rs2),
      .id_uses_rs1(bus.id_uses_rs1),
      .id_uses_rs2(bus.id_uses_rs2),
      .load_use   (load_use)
   );
   // classify the cycle by fixed hazard priority: memory stall, MC wait, mispredict, MC start, load-use
   always_comb begin
      mem_stall = mem_stall_f(bus.imem_pending, bus.imem_resp, bus.dmem_pending, bus.dmem_resp);
      in_run    = (state_q == RUN) & ~mem_stall;
      mc_hold   = (state_q == MC_WAIT) & ~mem_stall & ~bus.ex_mc_done & (mc_cnt_q < MC_LAST);
      p_flush   = in_run & bus.ex_mispredict;
      p_start   = in_run & ~bus.ex_mispredict & bus.ex_mc_start;
      p_bubble  = in_run & ~bus.ex_mispredict & ~bus.ex_mc_start & load_use;
   end
   // register enables and bubble inserts, all forced low during reset
   always_comb begin
      ld_front          = ~(mem_stall | mc_hold | p_start | p_bubble);
      ld_mid            = ~(mem_stall | mc_hold | p_start);
      bus.load_pc       = ~rst & ld_front;
      bus.load_if_id    = ~rst & ld_front;
      bus.load_id_exe   = ~rst & ld_mid;
      bus.load_exe_mem  = ~rst & ld_mid;
      bus.load_mem_wb   = ~rst & ~mem_stall;
      bus.flush_if_id   = ~rst & p_flush;
      bus.flush_id_exe  = ~rst & (p_flush | p_bubble);
      bus.flush_exe_mem = 1'b0;
      bus.mc_timeout    = mc_timeout_q;
   end
   // multicycle wait FSM: count while waiting, leave on done or on the last allowed cycle
   always_comb begin
      state_d      = state_q;
      mc_cnt_d     = mc_cnt_q;
      mc_timeout_d = mc_timeout_q;
      if (mc_hold) begin
         mc_cnt_d = mc_cnt_q + MC_CNT_W'(1);
      end else if ((state_q == MC_WAIT) & ~mem_stall) begin
         state_d      = RUN;
         mc_cnt_d     = '0;
         mc_timeout_d = mc_timeout_q | ~bus.ex_mc_done;
      end else if (p_start) begin
         state_d  = MC_WAIT;
         mc_cnt_d = '0;
      end
   end
   // state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         mc_cnt_q     <= '0;
         mc_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mc_cnt_q     <= mc_cnt_d;
         mc_timeout_q <= mc_timeout_d;
      end
   end
`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, bubble_cnt_q, bubble_cnt_d;
   // saturating event counters for stall, flush and bubble cycles
   always_comb begin
      stall_cnt_d           = stall_cnt_q + CNT_W'(mem_stall & ~&stall_cnt_q);
      flush_cnt_d           = flush_cnt_q + CNT_W'(p_flush & ~&flush_cnt_q);
      bubble_cnt_d          = bubble_cnt_q + CNT_W'(p_bubble & ~&bubble_cnt_q);
      bus.perf_stall_cycles = stall_cnt_q;
      bus.perf_flushes      = flush_cnt_q;
      bus.perf_bubbles      = bubble_cnt_q;
   end
   // counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random stimulus against a cycle-category reference model
module tb_pipeline_ctrl;
   localparam int T = 8;
   typedef struct packed {
      logic rst, ip, ir, dp, dr, u1, u2, is_load, misp, start, done;
      logic [4:0] rs1, rs2, ex_rd;
   } stim_t;
   // expected {load_pc,load_if_id,load_id_exe,load_exe_mem,load_mem_wb,flush_if_id,flush_id_exe,flush_exe_mem}
   // per category: reset, mem stall, mc hold, mc exit, mispredict, mc start, load-use bubble, normal
   localparam logic [7:0] OUT_TAB [8] = '{8'h00, 8'h00, 8'h08, 8'hF8, 8'hFE, 8'h08, 8'h3A, 8'hF8};
   logic clk = 1'b0;
   logic rst;
   int n_chk = 0, n_fail = 0;
   bit m_wait = 0, m_err = 0;
   int m_waited = 0, m_stalls = 0, m_flushes = 0, m_bubbles = 0;
   pipeline_ctrl_if bus ();
   pipeline_ctrl #(.MC_TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic stim_t idle();
      stim_t s = '0;
      return s;
   endfunction

   function automatic int category(input stim_t s);
      if (s.rst) return 0;
      if ((s.ip && !s.ir) || (s.dp && !s.dr)) return 1;
      if (m_wait) return (!s.done && m_waited < T - 1) ? 2 : 3;
      if (s.misp) return 4;
      if (s.start) return 5;
      if (s.is_load && s.ex_rd != 0 && ((s.u1 && s.rs1 == s.ex_rd) || (s.u2 && s.rs2 == s.ex_rd))) return 6;
      return 7;
   endfunction

   task automatic apply(input stim_t s);
      rst = s.rst;
      bus.imem_pending = s.ip;  bus.imem_resp = s.ir;
      bus.dmem_pending = s.dp;  bus.dmem_resp = s.dr;
      bus.id_uses_rs1 = s.u1;   bus.id_uses_rs2 = s.u2;
      bus.id_rs1 = s.rs1;       bus.id_rs2 = s.rs2;      bus.ex_rd = s.ex_rd;
      bus.ex_is_load = s.is_load; bus.ex_mispredict = s.misp;
      bus.ex_mc_start = s.start;  bus.ex_mc_done = s.done;
   endtask

   task automatic step(input string tag, input stim_t s);
      int cat;
      @(negedge clk);
      apply(s);
      #1;
      cat = category(s);
      check({tag, ":outs"}, 32'({bus.load_pc, bus.load_if_id, bus.load_id_exe, bus.load_exe_mem,
             bus.load_mem_wb, bus.flush_if_id, bus.flush_id_exe, bus.flush_exe_mem}), 32'(OUT_TAB[cat]));
      check({tag, ":mc_timeout"}, 32'(bus.mc_timeout), 32'(m_err));
`ifdef PIPE_CTRL_PERF_EN
      check({tag, ":perf_stall"}, bus.perf_stall_cycles, m_stalls);
      check({tag, ":perf_flush"}, bus.perf_flushes, m_flushes);
      check({tag, ":perf_bubble"}, bus.perf_bubbles, m_bubbles);
`endif
      @(posedge clk);
      case (cat)
         0: begin m_wait = 0; m_waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0; m_bubbles = 0; end
         1: m_stalls++;
         2: m_waited++;
         3: begin m_wait = 0; m_waited = 0; m_err = m_err | !s.done; end
         4: m_flushes++;
         5: begin m_wait = 1; m_waited = 0; end
         6: m_bubbles++;
         default: ;
      endcase
   endtask

   initial begin
      stim_t s;
      s = idle();
      s.rst = 1'b1;
      apply(s);
      step("reset", s);
      step("reset2", s);
      s = idle(); s.is_load = 1; s.ex_rd = 5; s.rs1 = 5; s.u1 = 1;
      step("load_use", s);
      step("after_lu", idle());
      s.ex_rd = 0; s.rs1 = 0;
      step("lu_x0", s);
      s = idle(); s.dp = 1;
      repeat (3) step("mem_stall", s);
      s.dr = 1;
      step("mem_resp", s);
      s = idle(); s.misp = 1; s.is_load = 1; s.ex_rd = 3; s.rs2 = 3; s.u2 = 1;
      step("misp_lu", s);
      s = idle(); s.start = 1;
      step("mul_start", s);
      repeat (3) step("mul_wait", idle());
      s = idle(); s.done = 1;
      step("mul_done", s);
      step("mul_run", idle());
      s = idle(); s.start = 1;
      step("to_start", s);
      repeat (9) step("to_wait", idle());
      s = idle(); s.start = 1;
      step("to_sticky", s);
      step("mid_wait", idle());
      s = idle(); s.dp = 1;
      step("mc_stall", s);
      s = idle(); s.rst = 1;
      step("rst_mid", s);
      step("post_rst", idle());
      for (int i = 0; i < 3000; i++) begin
         s.rst     = 1'($urandom_range(0, 99) == 0);
         s.ip      = 1'($urandom_range(0, 4) == 0);
         s.ir      = 1'($urandom_range(0, 1));
         s.dp      = 1'($urandom_range(0, 4) == 0);
         s.dr      = 1'($urandom_range(0, 1));
         s.u1      = 1'($urandom_range(0, 1));
         s.u2      = 1'($urandom_range(0, 1));
         s.is_load = 1'($urandom_range(0, 1));
         s.misp    = 1'($urandom_range(0, 9) == 0);
         s.start   = 1'($urandom_range(0, 7) == 0);
         s.done    = 1'($urandom_range(0, 5) == 0);
         s.rs1     = 5'($urandom_range(0, 3));
         s.rs2     = 5'($urandom_range(0, 3));
         s.ex_rd   = 5'($urandom_range(0, 3));
         step("rand", s);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
